uart_rx_fifo: RTL

//  Receive buffer directly downstream of the UART receiver. Captures each byte on the receiver's
//  one-cycle done pulse, queues up to DEPTH bytes for the host/bus side, and records frame errors
//  and overruns. Output is first-word-fall-through with a valid/pop read handshake.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_fifo_mem.sv | 43 ++++
 rtl/uart_rx_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default widths, sticky flag struct, clog2 helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Character width produced by the UART receiver.
    localparam int UART_DATA_BITS = 8;

    // Width of the saturating frame-error counter.
    localparam int UART_ECNT_W = 8;

    // Sticky error flags held by the receive buffer. Both are set by events
    // and cleared only by reset or clr_err.
    typedef struct packed {
        logic overrun;    // a received byte was dropped because the buffer was full
        logic frame_err;  // at least one bad stop bit was seen
    } uart_sticky_t;

    // Ceiling log2, used to size pointers from a depth parameter.
    // Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive buffer: DEPTH x DATA_BITS, one sync write port, one async read port.
// Latency: write lands at the clock edge; read is combinational from raddr.
// Backpressure: none; the caller decides when we is allowed.
//
// Ports:
//   clk    in   write clock
//   we     in   write enable, sampled on the rising edge
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
//
// Contents are deliberately not reset: occupancy is tracked by the pointers
// in the parent, so stale entries are never presented as valid data.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read: when the same entry is written and read in one
    // cycle (full with push and pop together), the old head is returned and
    // the new byte only lands at the edge.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures bytes on rx_done, FWFT read side with valid/pop, sticky overrun/frame-error flags.
// Latency: a byte pushed at edge N appears on rd_data/rd_valid right after edge N; pops show the next entry with no bubble.
// Backpressure: none toward the receiver; a byte arriving while full (and no pop) is dropped and overrun is set.
//
// Ports:
//   clk          in   system clock, rising edge
//   arst_n       in   asynchronous reset, active low
//   rst          in   synchronous clear, active high, same effect as arst_n
//   rx_data      in   received byte, qualified by rx_done
//   rx_done      in   one-cycle pulse, byte complete with good stop bit
//   rx_err       in   one-cycle pulse, bad stop bit, no data
//   rd_en        in   pop request, ignored while rd_valid=0
//   clr_err      in   clears overrun, frame_err, err_cnt
//   rd_data      out  head entry, 0 while empty
//   rd_valid     out  buffer not empty
//   full         out  count == DEPTH
//   almost_full  out  count >= AFULL_LVL
//   count        out  occupancy 0..DEPTH
//   overrun      out  sticky, a byte was dropped
//   frame_err    out  sticky, an rx_err was seen
//   err_cnt      out  saturating count of rx_err since clear
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DEPTH     = 16,              // power of two, >= 2
    parameter int ADDR_W    = clog2(DEPTH),
    parameter int AFULL_LVL = 12,
    parameter int ECNT_W    = UART_ECNT_W
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_done,
    input  logic                 rx_err,
    input  logic                 rd_en,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_W:0]      count,
    output logic                 overrun,
    output logic                 frame_err,
    output logic [ECNT_W-1:0]    err_cnt
);

    localparam int PTR_W = ADDR_W + 1;

    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0]  DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  AFULL_C = PTR_W'(AFULL_LVL);
    localparam logic [ECNT_W-1:0] ECNT_ONE = ECNT_W'(1);

    // Pointers carry one extra wrap bit so that equal low bits can be told
    // apart as empty (wrap bits equal) or full (wrap bits differ).
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    uart_sticky_t         sticky_q, sticky_d;
    logic [ECNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 mem_we;
    logic [DATA_BITS-1:0] mem_rdata;

    // ------------------------------------------------------------------
    // Status, all derived from registered pointers only, so nothing on the
    // receiver side has a combinational path to any output.
    // ------------------------------------------------------------------
    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        rd_valid    = (count != '0);
        full        = (count == DEPTH_C);
        almost_full = (count >= AFULL_C);
    end

    // ------------------------------------------------------------------
    // Handshake decode. A push into a full buffer is still accepted when a
    // pop frees the head slot in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pop    = rd_en & rd_valid;
        push   = rx_done & (~full | pop);
        drop   = rx_done & full & ~pop;
        mem_we = push & ~rst;
    end

    // ------------------------------------------------------------------
    // Pointer next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags and error counter. clr_err is applied first so that an
    // event in the same cycle wins: the flag ends set and the counter
    // restarts from zero, ending at one.
    // ------------------------------------------------------------------
    always_comb begin
        sticky_d  = sticky_q;
        err_cnt_d = err_cnt_q;
        if (rst) begin
            sticky_d  = '0;
            err_cnt_d = '0;
        end else begin
            if (clr_err) begin
                sticky_d  = '0;
                err_cnt_d = '0;
            end
            if (drop) begin
                sticky_d.overrun = 1'b1;
            end
            if (rx_err) begin
                sticky_d.frame_err = 1'b1;
                if (clr_err) begin
                    err_cnt_d = ECNT_ONE;
                end else if (&err_cnt_q) begin
                    err_cnt_d = err_cnt_q;
                end else begin
                    err_cnt_d = err_cnt_q + ECNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            sticky_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sticky_q  <= sticky_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    uart_fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs. rd_data is masked while empty because memory is not reset
    // and the head slot may hold a stale byte.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data   = rd_valid ? mem_rdata : '0;
        overrun   = sticky_q.overrun;
        frame_err = sticky_q.frame_err;
        err_cnt   = err_cnt_q;
    end

endmodule
